reg_file_rename: RTL and testbench

Architectural register file with rename tags for the out-of-order core. It records, at issue, which reorder-buffer entry will produce each register, and retires values when the reorder buffer commits them. It resolves decoder operand reads to either a value or a producer tag, querying the reorder buffer for already-finished producers. It sits between the decoder/issue stage and the reorder buffer, and is the consumer end of the reorder buffer's issue, commit and value-query interface.

---
 rtl/reg_file_rename.sv | 121 ++++++++++++
 tb/tb_reg_file_rename.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file_rename.sv
// reg_file_rename
//   Architectural register file with rename tags. At issue it records which
//   reorder-buffer entry will produce each destination register, and at commit
//   it retires values. Decoder operand reads resolve to a value (from state, from
//   the commit bypass, or from the reorder buffer) or to a producer tag.
//
// Ports
//   clk, rst                    clock; synchronous active-high reset
//   rdy                         global enable, low freezes all state
//   clear                       mispredict flush: drops all busy bits
//   issue_valid/rd/rob_id       rename a destination register to a ROB entry
//   commit_valid/rd/rob_id/value  retire a value from the ROB head
//   rs1, rs2                    decoder source register indices
//   get_rob_id1/2               tag of rs1/rs2 sent to the ROB for lookup
//   get_ready1/2, get_value1/2  ROB answer for the queried tag
//   val1/2, dep_valid1/2, dep1/2  resolved operands
module reg_file_rename #(
    parameter int ROB_SIZE_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      clear,
    input  logic                      issue_valid,
    input  logic [4:0]                issue_rd,
    input  logic [ROB_SIZE_WIDTH-1:0] issue_rob_id,
    input  logic                      commit_valid,
    input  logic [4:0]                commit_rd,
    input  logic [ROB_SIZE_WIDTH-1:0] commit_rob_id,
    input  logic [31:0]               commit_value,
    input  logic [4:0]                rs1,
    input  logic [4:0]                rs2,
    output logic [ROB_SIZE_WIDTH-1:0] get_rob_id1,
    output logic [ROB_SIZE_WIDTH-1:0] get_rob_id2,
    input  logic                      get_ready1,
    input  logic                      get_ready2,
    input  logic [31:0]               get_value1,
    input  logic [31:0]               get_value2,
    output logic [31:0]               val1,
    output logic [31:0]               val2,
    output logic                      dep_valid1,
    output logic                      dep_valid2,
    output logic [ROB_SIZE_WIDTH-1:0] dep1,
    output logic [ROB_SIZE_WIDTH-1:0] dep2
);

    // Entry 0 is never written outside reset, so x0 stays 0 / not busy / tag 0
    // and synthesis trims it to constants.
    logic [31:0]               r_value [0:31];
    logic [ROB_SIZE_WIDTH-1:0] r_tag   [0:31];
    logic [31:0]               r_busy;

    logic w_commit_hit1;
    logic w_commit_hit2;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_value[i] <= '0;
                r_tag[i]   <= '0;
            end
            r_busy <= '0;
        end else if (rdy) begin
            if (commit_valid && commit_rd != 5'd0) begin
                r_value[commit_rd] <= commit_value;
                // Only the current owner releases the register; an older
                // producer retiring must not unbusy a younger renaming.
                if (r_tag[commit_rd] == commit_rob_id)
                    r_busy[commit_rd] <= 1'b0;
            end
            // Issue is placed after commit so it wins busy on a same-register
            // collision; the commit value write above is unaffected.
            if (clear) begin
                r_busy <= '0;
            end else if (issue_valid && issue_rd != 5'd0) begin
                r_busy[issue_rd] <= 1'b1;
                r_tag[issue_rd]  <= issue_rob_id;
            end
        end
    end

    // Commit bypass: the ROB head currently retiring is the register's owner.
    assign w_commit_hit1 = commit_valid && (commit_rd == rs1) && (commit_rob_id == r_tag[rs1]);
    assign w_commit_hit2 = commit_valid && (commit_rd == rs2) && (commit_rob_id == r_tag[rs2]);

    assign get_rob_id1 = r_tag[rs1];
    assign get_rob_id2 = r_tag[rs2];

    always_comb begin
        val1       = '0;
        dep_valid1 = 1'b0;
        dep1       = '0;
        if (rs1 == 5'd0 || !r_busy[rs1]) begin
            val1 = r_value[rs1];
        end else if (w_commit_hit1) begin
            val1 = commit_value;
        end else if (get_ready1) begin
            val1 = get_value1;
        end else begin
            dep_valid1 = 1'b1;
            dep1       = r_tag[rs1];
        end
    end

    always_comb begin
        val2       = '0;
        dep_valid2 = 1'b0;
        dep2       = '0;
        if (rs2 == 5'd0 || !r_busy[rs2]) begin
            val2 = r_value[rs2];
        end else if (w_commit_hit2) begin
            val2 = commit_value;
        end else if (get_ready2) begin
            val2 = get_value2;
        end else begin
            dep_valid2 = 1'b1;
            dep2       = r_tag[rs2];
        end
    end

endmodule

// File: tb/tb_reg_file_rename.sv
module tb_reg_file_rename;

    localparam int W = 4;

    logic          clk = 1'b0;
    logic          rst, rdy, clear;
    logic          issue_valid;
    logic [4:0]    issue_rd;
    logic [W-1:0]  issue_rob_id;
    logic          commit_valid;
    logic [4:0]    commit_rd;
    logic [W-1:0]  commit_rob_id;
    logic [31:0]   commit_value;
    logic [4:0]    rs1, rs2;
    logic [W-1:0]  get_rob_id1, get_rob_id2;
    logic          get_ready1, get_ready2;
    logic [31:0]   get_value1, get_value2;
    logic [31:0]   val1, val2;
    logic          dep_valid1, dep_valid2;
    logic [W-1:0]  dep1, dep2;

    always #5 clk = ~clk;

    reg_file_rename #(.ROB_SIZE_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rob_id(issue_rob_id),
        .commit_valid(commit_valid), .commit_rd(commit_rd),
        .commit_rob_id(commit_rob_id), .commit_value(commit_value),
        .rs1(rs1), .rs2(rs2),
        .get_rob_id1(get_rob_id1), .get_rob_id2(get_rob_id2),
        .get_ready1(get_ready1), .get_ready2(get_ready2),
        .get_value1(get_value1), .get_value2(get_value2),
        .val1(val1), .val2(val2),
        .dep_valid1(dep_valid1), .dep_valid2(dep_valid2),
        .dep1(dep1), .dep2(dep2)
    );

    typedef struct {
        logic         rst, rdy, clear;
        logic         iv;
        logic [4:0]   ird;
        logic [W-1:0] irob;
        logic         cv;
        logic [4:0]   crd;
        logic [W-1:0] crob;
        logic [31:0]  cval;
        logic [4:0]   rs1, rs2;
        logic         gr1, gr2;
        logic [31:0]  gv1, gv2;
        logic         chk;
        logic         chk_gid;
        logic [31:0]  e_val1, e_val2;
        logic         e_dv1, e_dv2;
        logic [W-1:0] e_dep1, e_dep2, e_gid1, e_gid2;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t idle();
        vec_t r;
        r.rst = 0; r.rdy = 1; r.clear = 0;
        r.iv = 0; r.ird = 0; r.irob = 0;
        r.cv = 0; r.crd = 0; r.crob = 0; r.cval = 0;
        r.rs1 = 0; r.rs2 = 0; r.gr1 = 0; r.gr2 = 0; r.gv1 = 0; r.gv2 = 0;
        r.chk = 1; r.chk_gid = 1;
        r.e_val1 = 0; r.e_val2 = 0; r.e_dv1 = 0; r.e_dv2 = 0;
        r.e_dep1 = 0; r.e_dep2 = 0; r.e_gid1 = 0; r.e_gid2 = 0;
        return r;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t r);
        rst = r.rst; rdy = r.rdy; clear = r.clear;
        issue_valid = r.iv; issue_rd = r.ird; issue_rob_id = r.irob;
        commit_valid = r.cv; commit_rd = r.crd; commit_rob_id = r.crob; commit_value = r.cval;
        rs1 = r.rs1; rs2 = r.rs2;
        get_ready1 = r.gr1; get_ready2 = r.gr2; get_value1 = r.gv1; get_value2 = r.gv2;
    endtask

    // Drive one row at the falling edge, sample mid-low-phase, state updates
    // on the following rising edge.
    task automatic apply(input vec_t r, input int row);
        vec_t e;
        @(negedge clk);
        drive(r);
        sb.push_back(r);
        #2;
        e = sb.pop_front();
        if (e.chk) begin
            chk("val1", row, val1, e.e_val1);
            chk("dep_valid1", row, 32'(dep_valid1), 32'(e.e_dv1));
            chk("dep1", row, 32'(dep1), 32'(e.e_dep1));
            chk("val2", row, val2, e.e_val2);
            chk("dep_valid2", row, 32'(dep_valid2), 32'(e.e_dv2));
            chk("dep2", row, 32'(dep2), 32'(e.e_dep2));
            if (e.chk_gid) begin
                chk("get_rob_id1", row, 32'(get_rob_id1), 32'(e.e_gid1));
                chk("get_rob_id2", row, 32'(get_rob_id2), 32'(e.e_gid2));
            end
        end
    endtask

    task automatic add_rows();
        vec_t r;
        // reset state
        r = idle(); r.rs1 = 5; vecs.push_back(r);
        // issue x3 -> 7; same-cycle read sees the pre-issue state
        r = idle(); r.iv = 1; r.ird = 3; r.irob = 7; r.rs1 = 3; vecs.push_back(r);
        r = idle(); r.rs1 = 3; r.e_dv1 = 1; r.e_dep1 = 7; r.e_gid1 = 7; vecs.push_back(r);
        r = idle(); r.rs1 = 3; r.gr1 = 1; r.gv1 = 32'h55; r.e_val1 = 32'h55; r.e_gid1 = 7; vecs.push_back(r);
        // rename x3 twice, retire the older producer
        r = idle(); r.iv = 1; r.ird = 3; r.irob = 2; r.rs1 = 3; r.e_dv1 = 1; r.e_dep1 = 7; r.e_gid1 = 7; vecs.push_back(r);
        r = idle(); r.iv = 1; r.ird = 3; r.irob = 5; r.rs1 = 3; r.e_dv1 = 1; r.e_dep1 = 2; r.e_gid1 = 2; vecs.push_back(r);
        r = idle(); r.cv = 1; r.crd = 3; r.crob = 2; r.cval = 32'hAA; r.rs1 = 3;
        r.e_dv1 = 1; r.e_dep1 = 5; r.e_gid1 = 5; vecs.push_back(r);
        r = idle(); r.rs1 = 3; r.rs2 = 3; r.gr2 = 1; r.gv2 = 32'h77;
        r.e_dv1 = 1; r.e_dep1 = 5; r.e_gid1 = 5; r.e_val2 = 32'h77; r.e_gid2 = 5; vecs.push_back(r);
        r = idle(); r.cv = 1; r.crd = 3; r.crob = 5; r.cval = 32'hBB; r.rs1 = 3;
        r.e_val1 = 32'hBB; r.e_gid1 = 5; vecs.push_back(r);
        r = idle(); r.rs1 = 3; r.e_val1 = 32'hBB; r.e_gid1 = 5; vecs.push_back(r);
        // issue and commit collide on x4: issue keeps busy/tag, commit writes value
        r = idle(); r.iv = 1; r.ird = 4; r.irob = 1; r.rs1 = 4; vecs.push_back(r);
        r = idle(); r.iv = 1; r.ird = 4; r.irob = 9; r.cv = 1; r.crd = 4; r.crob = 1; r.cval = 32'h10;
        r.rs1 = 4; r.e_val1 = 32'h10; r.e_gid1 = 1; vecs.push_back(r);
        r = idle(); r.rs1 = 4; r.rs2 = 4; r.e_dv1 = 1; r.e_dep1 = 9; r.e_gid1 = 9;
        r.e_dv2 = 1; r.e_dep2 = 9; r.e_gid2 = 9; vecs.push_back(r);
        // commit bypass on x6, then ROB answer ignored once not busy
        r = idle(); r.iv = 1; r.ird = 6; r.irob = 12; r.rs1 = 6; vecs.push_back(r);
        r = idle(); r.cv = 1; r.crd = 6; r.crob = 12; r.cval = 32'h1234; r.rs1 = 6;
        r.e_val1 = 32'h1234; r.e_gid1 = 12; vecs.push_back(r);
        r = idle(); r.rs1 = 6; r.gr1 = 1; r.gv1 = 32'hDEAD; r.e_val1 = 32'h1234; r.e_gid1 = 12; vecs.push_back(r);
        // flush with a dropped issue
        r = idle(); r.iv = 1; r.ird = 8; r.irob = 3; vecs.push_back(r);
        r = idle(); r.iv = 1; r.ird = 9; r.irob = 4; vecs.push_back(r);
        r = idle(); r.clear = 1; r.iv = 1; r.ird = 10; r.irob = 6; r.rs1 = 8; r.rs2 = 9;
        r.e_dv1 = 1; r.e_dep1 = 3; r.e_gid1 = 3; r.e_dv2 = 1; r.e_dep2 = 4; r.e_gid2 = 4; vecs.push_back(r);
        r = idle(); r.rs1 = 8; r.rs2 = 9; r.chk_gid = 0; vecs.push_back(r);
        r = idle(); r.rs1 = 10; r.rs2 = 4; r.e_val2 = 32'h10; r.chk_gid = 0; vecs.push_back(r);
        // x0 ignores issue/commit
        r = idle(); r.iv = 1; r.ird = 0; r.irob = 5; r.cv = 1; r.crd = 0; r.crob = 5; r.cval = 32'hFFFF; vecs.push_back(r);
        r = idle(); r.gr1 = 1; r.gv1 = 32'h42; vecs.push_back(r);
        // rdy low freezes state
        r = idle(); r.rdy = 0; r.iv = 1; r.ird = 11; r.irob = 3; r.cv = 1; r.crd = 3; r.crob = 5; r.cval = 32'h99;
        r.rs1 = 3; r.rs2 = 11; r.e_val1 = 32'hBB; r.e_gid1 = 5; vecs.push_back(r);
        r = idle(); r.rs1 = 3; r.rs2 = 11; r.e_val1 = 32'hBB; r.e_gid1 = 5; vecs.push_back(r);
        r = idle(); r.iv = 1; r.ird = 12; r.irob = 2; vecs.push_back(r);
        r = idle(); r.rdy = 0; r.cv = 1; r.crd = 12; r.crob = 2; r.cval = 32'h5; r.rs1 = 12;
        r.e_val1 = 32'h5; r.e_gid1 = 2; vecs.push_back(r);
        r = idle(); r.rs1 = 12; r.e_dv1 = 1; r.e_dep1 = 2; r.e_gid1 = 2; vecs.push_back(r);
    endtask

    initial begin
        vec_t r;
        r = idle();
        r.rst = 1;
        drive(r);
        repeat (2) @(posedge clk);

        add_rows();
        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], i);

        // Synchronous reset mid-run wins over a same-cycle issue and commit.
        r = idle(); r.rst = 1; r.iv = 1; r.ird = 12; r.irob = 7;
        r.cv = 1; r.crd = 6; r.crob = 12; r.cval = 32'h77; r.chk = 0;
        apply(r, 100);
        r = idle(); r.rs1 = 12; r.rs2 = 6;
        apply(r, 101);
        r = idle(); r.rs1 = 4; r.rs2 = 3;
        apply(r, 102);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
